// File: rtl/sonar_scanner.sv
// Round-robin multi-channel ultrasonic ranger: self-timed trigger pulses, echo high
// time converted to millimetres by a prescaler, with timeout, masking and guard gap.
module sonar_scanner #(
    parameter int NCH         = 4,
    parameter int CH_W        = 2,
    parameter int DIST_W      = 16,
    parameter int TRIG_CYC    = 500,
    parameter int MM_CYC      = 291,
    parameter int TIMEOUT_CYC = 1500000,
    parameter int GAP_CYC     = 3000000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              cont_mode_i,
    input  logic [NCH-1:0]    ch_en_i,
    input  logic [NCH-1:0]    echo_i,
    output logic [NCH-1:0]    trig_o,
    output logic              busy_o,
    output logic              valid_o,
    output logic [CH_W-1:0]   ch_id_o,
    output logic [DIST_W-1:0] distance_o,
    output logic              timeout_o
);
    localparam int MAX_TG  = (TRIG_CYC > GAP_CYC) ? TRIG_CYC : GAP_CYC;
    localparam int MAX_CYC = (TIMEOUT_CYC > MAX_TG) ? TIMEOUT_CYC : MAX_TG;
    localparam int CW      = $clog2(MAX_CYC + 2);
    localparam int PW      = (MM_CYC > 1) ? $clog2(MM_CYC) : 1;

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, REPORT, GAP} state_t;

    state_t            state_q;
    logic [NCH-1:0]    echo_m_q;
    logic [NCH-1:0]    echo_s_q;
    logic [NCH-1:0]    trig_q;
    logic [CH_W-1:0]   ptr_q;
    logic [CH_W-1:0]   cur_q;
    logic [CH_W-1:0]   ch_id_q;
    logic [CH_W-1:0]   nxt_ch;
    logic              nxt_ok;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;
    logic [PW-1:0]     presc_q;
    logic [PW-1:0]     presc_d;
    logic [DIST_W-1:0] dcnt_q;
    logic [DIST_W-1:0] dcnt_d;
    logic [DIST_W-1:0] dist_q;
    logic              busy_q;
    logic              valid_q;
    logic              tmo_q;
    logic              echo_cur;

    assign echo_cur = echo_s_q[cur_q];
    assign cnt_d    = cnt_q + 1'b1;

    // First enabled channel strictly after the pointer; smallest distance wins.
    always_comb begin
        nxt_ch = ptr_q;
        nxt_ok = 1'b0;
        for (int k = NCH; k >= 1; k--) begin
            for (int j = 0; j < NCH; j++) begin
                if (ch_en_i[j] && (j == (int'(ptr_q) + k) % NCH)) begin
                    nxt_ch = CH_W'(j);
                    nxt_ok = 1'b1;
                end
            end
        end
    end

    // One echo-high tick; the rising-edge cycle in WAIT_RISE counts from zero.
    always_comb begin
        presc_d = (state_q == MEASURE) ? presc_q : '0;
        dcnt_d  = (state_q == MEASURE) ? dcnt_q : '0;
        if (presc_d == PW'(MM_CYC - 1)) begin
            presc_d = '0;
            if (dcnt_d != '1) begin
                dcnt_d = dcnt_d + 1'b1;
            end
        end else begin
            presc_d = presc_d + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            echo_m_q <= '0;
            echo_s_q <= '0;
            trig_q   <= '0;
            ptr_q    <= CH_W'(NCH - 1);
            cur_q    <= '0;
            ch_id_q  <= '0;
            cnt_q    <= '0;
            presc_q  <= '0;
            dcnt_q   <= '0;
            dist_q   <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            echo_m_q <= echo_i;
            echo_s_q <= echo_m_q;
            valid_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if ((start_i || cont_mode_i) && nxt_ok) begin
                        state_q <= TRIG;
                        cur_q   <= nxt_ch;
                        trig_q  <= NCH'(1) << nxt_ch;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                TRIG: begin
                    if (cnt_q == CW'(TRIG_CYC - 1)) begin
                        state_q <= WAIT_RISE;
                        trig_q  <= '0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                WAIT_RISE: begin
                    if (echo_cur) begin
                        state_q <= MEASURE;
                        presc_q <= presc_d;
                        dcnt_q  <= dcnt_d;
                        cnt_q   <= cnt_d;
                    end else if (cnt_d >= CW'(TIMEOUT_CYC)) begin
                        state_q <= REPORT;
                        valid_q <= 1'b1;
                        ch_id_q <= cur_q;
                        dist_q  <= '1;
                        tmo_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                MEASURE: begin
                    if (!echo_cur) begin
                        state_q <= REPORT;
                        valid_q <= 1'b1;
                        ch_id_q <= cur_q;
                        dist_q  <= dcnt_q;
                        tmo_q   <= 1'b0;
                    end else if (cnt_d >= CW'(TIMEOUT_CYC)) begin
                        state_q <= REPORT;
                        valid_q <= 1'b1;
                        ch_id_q <= cur_q;
                        dist_q  <= '1;
                        tmo_q   <= 1'b1;
                    end else begin
                        presc_q <= presc_d;
                        dcnt_q  <= dcnt_d;
                        cnt_q   <= cnt_d;
                    end
                end
                REPORT: begin
                    // The guard gap is measured from the result strobe itself.
                    state_q <= GAP;
                    ptr_q   <= cur_q;
                    cnt_q   <= CW'(1);
                end
                GAP: begin
                    if (cnt_q >= CW'(GAP_CYC - 1)) begin
                        if (cont_mode_i && nxt_ok) begin
                            state_q <= TRIG;
                            cur_q   <= nxt_ch;
                            trig_q  <= NCH'(1) << nxt_ch;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    trig_q  <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign trig_o     = trig_q;
    assign busy_o     = busy_q;
    assign valid_o    = valid_q;
    assign ch_id_o    = ch_id_q;
    assign distance_o = dist_q;
    assign timeout_o  = tmo_q;

endmodule

// File: tb/tb_sonar_scanner.sv
// Directed and randomized pings on sonar_scanner; results are compared with a
// behavioural model of channel order, mm conversion, timeout and gap timing.
module tb_sonar_scanner;
    localparam int NCH         = 4;
    localparam int TRIG_CYC    = 10;
    localparam int MM_CYC      = 4;
    localparam int TIMEOUT_CYC = 200;
    localparam int GAP_CYC     = 20;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic           start_i;
    logic           cont_mode_i;
    logic [NCH-1:0] ch_en_i;
    logic [NCH-1:0] echo_i;
    logic [NCH-1:0] trig_o;
    logic           busy_o;
    logic           valid_o;
    logic [1:0]     ch_id_o;
    logic [15:0]    distance_o;
    logic           timeout_o;
    logic [NCH-1:0] trig_s;
    logic           busy_s;
    logic           valid_s;
    logic [1:0]     ch_id_s;
    logic [3:0]     dist_s;
    logic           tmo_s;

    int checks = 0;
    int errors = 0;
    int ptr    = NCH - 1;
    int npings = 0;
    int vcount = 0;
    int onehot_bad = 0;
    int trig_cyc [NCH];

    sonar_scanner #(.NCH(NCH), .CH_W(2), .DIST_W(16), .TRIG_CYC(TRIG_CYC), .MM_CYC(MM_CYC),
                    .TIMEOUT_CYC(TIMEOUT_CYC), .GAP_CYC(GAP_CYC)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .cont_mode_i(cont_mode_i),
        .ch_en_i(ch_en_i), .echo_i(echo_i), .trig_o(trig_o), .busy_o(busy_o),
        .valid_o(valid_o), .ch_id_o(ch_id_o), .distance_o(distance_o), .timeout_o(timeout_o));

    sonar_scanner #(.NCH(NCH), .CH_W(2), .DIST_W(4), .TRIG_CYC(TRIG_CYC), .MM_CYC(MM_CYC),
                    .TIMEOUT_CYC(TIMEOUT_CYC), .GAP_CYC(GAP_CYC)) dut_s (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .cont_mode_i(cont_mode_i),
        .ch_en_i(ch_en_i), .echo_i(echo_i), .trig_o(trig_s), .busy_o(busy_s),
        .valid_o(valid_s), .ch_id_o(ch_id_s), .distance_o(dist_s), .timeout_o(tmo_s));

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (valid_o) vcount <= vcount + 1;
        if ($countones(trig_o) > 1) onehot_bad <= onehot_bad + 1;
        for (int i = 0; i < NCH; i++) begin
            if (trig_o[i]) trig_cyc[i] <= trig_cyc[i] + 1;
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int next_en(input int p, input logic [NCH-1:0] en);
        for (int i = 1; i <= NCH; i++) begin
            if (en[(p + i) % NCH]) return (p + i) % NCH;
        end
        return -1;
    endfunction

    function automatic int mm(input int h, input int maxv);
        if (h == 0) return maxv;
        return (h / MM_CYC > maxv) ? maxv : h / MM_CYC;
    endfunction

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        ptr = NCH - 1;
        step();
    endtask

    // One ping on channel ch: echo of h cycles starting d cycles after trigger end (h=0: none).
    task automatic ping(input int ch, input int d, input int h, input bit noise,
                        input bit spam, input bit to_idle);
        int n;
        n = 0;
        while (trig_o == '0 && n < 2000) begin step(); n++; end
        chk("trig_channel", 64'(trig_o), 64'(4'b0001 << ch));
        n = 0;
        while (trig_o != '0 && n < 100) begin step(); n++; end
        chk("trig_len", 64'(n), 64'(TRIG_CYC));
        if (to_idle) cont_mode_i = 1'b0;
        if (noise) ch_en_i = 4'($urandom_range(1, 15));
        n = 0;
        while (!valid_o && n < 1000) begin
            echo_i = noise ? 4'($urandom) : 4'b0000;
            echo_i[ch] = (h > 0 && n >= d && n < d + h);
            start_i = spam ? 1'($urandom) : 1'b0;
            step();
            n++;
        end
        start_i = 1'b0;
        echo_i  = '0;
        npings++;
        chk("valid_seen", 64'(valid_o), 64'(1));
        if (h == 0) chk("timeout_latency", 64'(n), 64'(TIMEOUT_CYC));
        chk("ch_id", 64'(ch_id_o), 64'(ch));
        chk("distance", 64'(distance_o), 64'(mm(h, 65535)));
        chk("timeout", 64'(timeout_o), 64'(h == 0));
        chk("distance_w4", 64'(dist_s), 64'(mm(h, 15)));
        step();
        chk("valid_pulse", 64'(valid_o), 64'(0));
        if (to_idle) begin
            n = 1;
            while (busy_o && n < 100) begin step(); n++; end
            chk("busy_fall", 64'(n), 64'(GAP_CYC));
            chk("distance_hold", 64'(distance_o), 64'(mm(h, 65535)));
        end
    endtask

    task automatic shot(input int d, input int h, input bit noise, input bit spam);
        int ch;
        ch = next_en(ptr, ch_en_i);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        ping(ch, d, h, noise, spam, 1'b1);
        ptr = ch;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: observed still running, expected finished");
        $fatal(1);
    end

    initial begin
        int vsnap;
        int t0;
        int t2;
        int n;
        int h;
        int ch;
        rst_i = 1'b1;
        start_i = 1'b0;
        cont_mode_i = 1'b0;
        ch_en_i = '0;
        echo_i = '0;
        repeat (3) step();
        chk("rst_trig", 64'(trig_o), 64'(0));
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_valid", 64'(valid_o), 64'(0));
        chk("rst_ch_id", 64'(ch_id_o), 64'(0));
        chk("rst_distance", 64'(distance_o), 64'(0));
        chk("rst_timeout", 64'(timeout_o), 64'(0));
        rst_i = 1'b0;
        step();

        ch_en_i = 4'b1111;
        shot($urandom_range(0, 20), 40, 1'b0, 1'b0);

        do_reset();
        shot(0, 0, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            ch_en_i = 4'($urandom_range(1, 15));
            h = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 150));
            shot($urandom_range(0, 40), h, 1'b1, 1'b0);
        end

        t0 = trig_cyc[0];
        t2 = trig_cyc[2];
        ch_en_i = 4'b1010;
        cont_mode_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ch = next_en(ptr, ch_en_i);
            ping(ch, $urandom_range(0, 30), (ch == 1) ? 8 : 12, 1'b0, 1'b0, i == 3);
            ptr = ch;
        end
        chk("masked_ch0_trig", 64'(trig_cyc[0]), 64'(t0));
        chk("masked_ch2_trig", 64'(trig_cyc[2]), 64'(t2));

        ch_en_i = 4'b1111;
        shot($urandom_range(0, 20), 100, 1'b0, 1'b0);

        shot($urandom_range(0, 20), $urandom_range(1, 150), 1'b0, 1'b1);
        vsnap = vcount;
        t0 = trig_cyc[0] + trig_cyc[1] + trig_cyc[2] + trig_cyc[3];
        repeat (40) step();
        chk("busy_start_ignored", 64'(vcount), 64'(vsnap));
        ch_en_i = 4'b0000;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (40) step();
        chk("no_en_busy", 64'(busy_o), 64'(0));
        chk("no_en_valid", 64'(vcount), 64'(vsnap));
        chk("no_en_trig", 64'(trig_cyc[0] + trig_cyc[1] + trig_cyc[2] + trig_cyc[3]), 64'(t0));

        ch_en_i = 4'b1111;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (3) step();
        rst_i = 1'b1;
        #1;
        chk("rst_trig_async", 64'(trig_o), 64'(0));
        step();
        rst_i = 1'b0;
        ptr = NCH - 1;
        step();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        n = 0;
        while (trig_o != '0 && n < 100) begin step(); n++; end
        echo_i[0] = 1'b1;
        repeat (20) step();
        rst_i = 1'b1;
        #1;
        chk("rst_meas_trig", 64'(trig_o), 64'(0));
        chk("rst_meas_busy", 64'(busy_o), 64'(0));
        chk("rst_meas_valid", 64'(valid_o), 64'(0));
        chk("rst_meas_ch_id", 64'(ch_id_o), 64'(0));
        chk("rst_meas_distance", 64'(distance_o), 64'(0));
        chk("rst_meas_timeout", 64'(timeout_o), 64'(0));
        step();
        step();
        rst_i = 1'b0;
        echo_i = '0;
        repeat (30) step();
        chk("rst_no_valid", 64'(vcount), 64'(vsnap));
        shot($urandom_range(0, 20), $urandom_range(1, 150), 1'b0, 1'b0);

        step();
        chk("valid_total", 64'(vcount), 64'(npings));
        chk("trig_onehot", 64'(onehot_bad), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
